// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU:
//   - 5-bit ALU control codes, bit-exact with the ALU-control decoder output
//   - default datapath / register-address widths
//   - shift-amount width (shift ops use operand A bits [4:0])
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_REG_AW = 5;
  localparam int ALU_SHAMT_W = 5;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_XOR = 5'b01101;
  localparam logic [4:0] ALU_SLL = 5'b10000;
  localparam logic [4:0] ALU_SRL = 5'b10001;
  localparam logic [4:0] ALU_SRA = 5'b10010;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU.
// Ports:
//   alu_ctrl_i  5-bit decoded operation code (see alu_pkg)
//   sign_i      1 = signed SLT / overflow detection, 0 = unsigned
//   a_i         operand A; a_i[4:0] is the shift amount for shift ops
//   b_i         operand B; the value being shifted for shift ops
//   result_o    ALU result (0 for undefined codes)
//   ovf_o       two's-complement overflow for ADD/SUB when sign_i = 1
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [4:0]        alu_ctrl_i,
  input  logic              sign_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ovf_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0]      sum;
  logic [DATA_W-1:0]      diff;
  logic                   less;
  logic [ALU_SHAMT_W-1:0] shamt;

  assign sum   = a_i + b_i;
  assign diff  = a_i - b_i;
  assign shamt = a_i[ALU_SHAMT_W-1:0];
  assign less  = sign_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    case (alu_ctrl_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: begin
        result_o = sum;
        // Same-sign operands producing an opposite-sign sum.
        ovf_o    = sign_i & (a_i[MSB] == b_i[MSB]) & (sum[MSB] != a_i[MSB]);
      end
      ALU_SUB: begin
        result_o = diff;
        // Opposite-sign operands where the difference takes B's sign.
        ovf_o    = sign_i & (a_i[MSB] != b_i[MSB]) & (diff[MSB] != a_i[MSB]);
      end
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, less};
      ALU_NOR: result_o = ~(a_i | b_i);
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLL: result_o = b_i << shamt;
      ALU_SRL: result_o = b_i >> shamt;
      ALU_SRA: result_o = DATA_W'($signed(b_i) >>> shamt);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// -----------------------------------------------------------------------------
// ex_alu_stage
// Execute stage: computes the ALU result and registers it together with the
// destination metadata into the EX/MEM pipeline register (1-cycle latency).
// Per-edge priority: reset > flush > stall > load.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid              ID/EX slot holds a real instruction
//   stall                 hold EX/MEM contents
//   flush                 load a bubble (all-zero) into EX/MEM
//   ALUCtrl, Sign         decoded ALU op and signedness
//   in_a, in_b            operands
//   rd_in, reg_write_in   destination register and write-back enable
//   out_valid, out_result, out_zero, rd_out, reg_write_out   EX/MEM register
//   out_ovf               (EX_OVERFLOW_TRAP_EN only) signed ADD/SUB overflow
//
// Build option: define EX_OVERFLOW_TRAP_EN to add out_ovf and suppress the
// write-back of an overflowing slot. Without it ADD/SUB wrap silently.
// -----------------------------------------------------------------------------
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [4:0]        ALUCtrl,
  input  logic              Sign,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              reg_write_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [REG_AW-1:0] rd_out,
`ifdef EX_OVERFLOW_TRAP_EN
  output logic              out_ovf,
`endif
  output logic              reg_write_out
);

  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;
  logic              trap;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .alu_ctrl_i (ALUCtrl),
    .sign_i     (Sign),
    .a_i        (in_a),
    .b_i        (in_b),
    .result_o   (alu_result),
    .ovf_o      (alu_ovf)
  );

`ifdef EX_OVERFLOW_TRAP_EN
  assign trap = alu_ovf & in_valid;
`else
  logic unused_ovf;
  assign unused_ovf = alu_ovf;
  assign trap       = 1'b0;
`endif

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              ovf_q, ovf_d;

  // Next state: hold by default (stall), bubble on flush, otherwise load.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    zero_d   = zero_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    ovf_d    = ovf_q;
    if (flush) begin
      valid_d  = 1'b0;
      result_d = '0;
      zero_d   = 1'b0;
      rd_d     = '0;
      rw_d     = 1'b0;
      ovf_d    = 1'b0;
    end else if (!stall) begin
      valid_d  = in_valid;
      result_d = alu_result;
      zero_d   = (alu_result == '0);
      rd_d     = rd_in;
      // Writes to r0 are dropped here so later stages never see them.
      rw_d     = reg_write_in & in_valid & (rd_in != '0) & ~trap;
      ovf_d    = trap;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_result    = result_q;
  assign out_zero      = zero_q;
  assign rd_out        = rd_q;
  assign reg_write_out = rw_q;
`ifdef EX_OVERFLOW_TRAP_EN
  assign out_ovf       = ovf_q;
`else
  logic unused_ovf_q;
  assign unused_ovf_q = ovf_q;
`endif

endmodule
